// File: rtl/zynet_pkg.sv
// Shared types and default sizing for the ZyNet inference result path.
package zynet_pkg;

  // Default signed fixed-point score width and number of class scores per frame.
  localparam int DEF_WORD_SIZE   = 16;
  localparam int DEF_OUTPUT_SIZE = 10;

  // Result-reader sequencing: capture a vector, stream it out, then present argmax.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    RESULT = 2'd2
  } rr_state_e;

endpackage : zynet_pkg

// File: rtl/zynet_result_reader.sv
// Captures one network score vector, serializes the scores over a valid/ready
// port while tracking the running argmax, then presents the winning class index
// and its score on a separate valid/ready result port.
module zynet_result_reader
  import zynet_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0]  data_i,
  input  logic                              valid_i,
  output logic                              yumi_o,
  output logic [WORD_SIZE-1:0]              data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(OUTPUT_SIZE)-1:0]    class_o,
  output logic [WORD_SIZE-1:0]              max_o,
  output logic                              class_valid_o,
  input  logic                              class_ready_i
);

  localparam int                IDX_W    = $clog2(OUTPUT_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

  rr_state_e                     state_q, state_d;
  logic        [IDX_W-1:0]       index_q, index_d;
  logic        [IDX_W-1:0]       best_idx_q, best_idx_d;
  logic signed [WORD_SIZE-1:0]   best_val_q, best_val_d;
  logic signed [WORD_SIZE-1:0]   vec_q [OUTPUT_SIZE];
  logic signed [WORD_SIZE-1:0]   in_scores [OUTPUT_SIZE];
  logic signed [WORD_SIZE-1:0]   cur_score;
  logic                          capture;

  // Split the flat input bus into per-class signed scores.
  always_comb begin
    for (int k = 0; k < OUTPUT_SIZE; k++) begin
      in_scores[k] = data_i[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign cur_score = vec_q[index_q];

  // Next-state, handshake outputs and running argmax update.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    best_idx_d    = best_idx_q;
    best_val_d    = best_val_q;
    capture       = 1'b0;
    yumi_o        = 1'b0;
    valid_o       = 1'b0;
    class_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        yumi_o = valid_i;
        if (valid_i) begin
          capture    = 1'b1;
          state_d    = STREAM;
          index_d    = '0;
          best_idx_d = '0;
          best_val_d = '0;
        end
      end
      STREAM: begin
        valid_o = 1'b1;
        if (ready_i) begin
          // Strict greater-than keeps the lowest index on ties; element 0 always seeds.
          if ((index_q == '0) || (cur_score > best_val_q)) begin
            best_idx_d = index_q;
            best_val_d = cur_score;
          end
          if (index_q == LAST_IDX) begin
            index_d = '0;
            state_d = RESULT;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      RESULT: begin
        class_valid_o = 1'b1;
        if (class_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and argmax registers; reset discards any frame in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      index_q    <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  // Captured score vector, loaded only on the IDLE handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
        vec_q[k] <= '0;
      end
    end else if (capture) begin
      vec_q <= in_scores;
    end
  end

  assign data_o  = (state_q == STREAM) ? cur_score : '0;
  assign class_o = best_idx_q;
  assign max_o   = best_val_q;

endmodule : zynet_result_reader

// File: tb/tb_zynet_result_reader.sv
// Directed bench for zynet_result_reader: streams hand-built score frames and
// compares the serialized output and argmax result against fixed expectations.
module tb_zynet_result_reader;

  localparam int WS = 16;
  localparam int NO = 10;

  logic              clk;
  logic              reset_n_i;
  logic [NO*WS-1:0]  data_i;
  logic              valid_i;
  logic              yumi_o;
  logic [WS-1:0]     data_o;
  logic              valid_o;
  logic              ready_i;
  logic [3:0]        class_o;
  logic [WS-1:0]     max_o;
  logic              class_valid_o;
  logic              class_ready_i;

  logic [WS-1:0]     cur [NO];
  int                n_vec = 0;
  int                n_bad = 0;

  zynet_result_reader #(.WORD_SIZE(WS), .OUTPUT_SIZE(NO)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .yumi_o        (yumi_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .class_o       (class_o),
    .max_o         (max_o),
    .class_valid_o (class_valid_o),
    .class_ready_i (class_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    for (int k = 0; k < NO; k++) data_i[k*WS +: WS] = 16'($urandom);
  endtask

  // One frame: capture cur[], stream it, check the result, hand it back.
  task automatic frame(input int toggle, input int hold_res, input int abort_at,
                       input int exp_cls, input logic [WS-1:0] exp_max, input int exp_period);
    int cnt;
    int cyc;
    int guard;
    bit rdy;
    @(negedge clk);
    for (int k = 0; k < NO; k++) data_i[k*WS +: WS] = cur[k];
    valid_i = 1'b1; ready_i = 1'b1; class_ready_i = 1'b0;
    #1;
    chk("yumi_cap", yumi_o, 1);
    chk("vld_cap", valid_o, 0);
    cyc = 1; cnt = 0; guard = 0;
    while (cnt < NO && guard < 60) begin
      if (abort_at > 0 && cnt == abort_at) return;
      @(negedge clk);
      cyc++; guard++;
      valid_i = 1'b1;
      scramble_inputs();
      rdy = (toggle != 0) ? (((guard - 1) % 4 == 0) || ((guard - 1) % 4 == 3)) : 1'b1;
      ready_i = rdy;
      #1;
      chk("vld_str", valid_o, 1);
      chk("yumi_str", yumi_o, 0);
      chk("cvld_str", class_valid_o, 0);
      chk("data_o", data_o, cur[cnt]);
      if (rdy) cnt++;
    end
    if (cnt < NO) chk("stream_timeout", cnt, NO);
    @(negedge clk);
    cyc++;
    scramble_inputs();
    class_ready_i = (hold_res == 0);
    #1;
    chk("cvld_res", class_valid_o, 1);
    chk("vld_res", valid_o, 0);
    chk("yumi_res", yumi_o, 0);
    chk("class_o", class_o, exp_cls);
    chk("max_o", max_o, exp_max);
    for (int h = 0; h < hold_res; h++) begin
      @(negedge clk);
      cyc++;
      scramble_inputs();
      class_ready_i = (h == hold_res - 1);
      #1;
      chk("cvld_hold", class_valid_o, 1);
      chk("class_hold", class_o, exp_cls);
      chk("max_hold", max_o, exp_max);
    end
    @(negedge clk);
    cyc++;
    class_ready_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("cvld_idle", class_valid_o, 0);
    chk("vld_idle", valid_o, 0);
    chk("period", cyc - 1, exp_period);
  endtask

  task automatic load(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    cur[0] = 16'(v0); cur[1] = 16'(v1); cur[2] = 16'(v2); cur[3] = 16'(v3);
    cur[4] = 16'(v4); cur[5] = 16'(v5); cur[6] = 16'(v6); cur[7] = 16'(v7);
    cur[8] = 16'(v8); cur[9] = 16'(v9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; class_ready_i = 1'b0;
    data_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", valid_o, 0);
    chk("rst_cvld", class_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_class", class_o, 0);
    chk("rst_max", max_o, 0);
    chk("rst_yumi0", yumi_o, 0);
    valid_i = 1'b1;
    #1;
    chk("rst_yumi1", yumi_o, 1);
    @(negedge clk);
    valid_i = 1'b0; reset_n_i = 1'b1;

    // Baseline frame.
    load(1, 5, -3, 9, 2, 0, -8, 4, 7, 3);
    frame(0, 0, 0, 3, 16'd9, 12);
    // Signed compare among negatives, with result held for two cycles.
    load(-5, -5, -5, -5, -5, -5, -2, -5, -5, -5);
    frame(0, 2, 0, 6, 16'hFFFE, 14);
    // Tie resolves to lowest index.
    load(4, 9, 9, 1, 0, 0, 0, 0, 0, 0);
    frame(0, 0, 0, 1, 16'd9, 12);
    // All equal negative: element 0 must seed the maximum.
    load(-8, -8, -8, -8, -8, -8, -8, -8, -8, -8);
    frame(0, 0, 0, 0, 16'hFFF8, 12);
    // Downstream backpressure 1,0,0,1 pattern.
    load(1, 5, -3, 9, 2, 0, -8, 4, 7, 3);
    frame(1, 0, 0, 3, 16'd9, 22);

    // Reset mid-stream after the 4th transfer.
    load(1, 5, -3, 9, 2, 0, -8, 4, 7, 3);
    frame(0, 0, 4, 0, 16'd0, 0);
    @(negedge clk);
    reset_n_i = 1'b0; valid_i = 1'b1;
    #1;
    chk("arst_vld", valid_o, 0);
    chk("arst_cvld", class_valid_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_class", class_o, 0);
    chk("arst_max", max_o, 0);
    chk("arst_yumi", yumi_o, 1);
    @(negedge clk);
    reset_n_i = 1'b1; valid_i = 1'b0;
    #1;
    chk("post_rst_vld", valid_o, 0);
    chk("post_rst_cvld", class_valid_o, 0);
    @(negedge clk);
    #1;
    chk("post_rst_cvld2", class_valid_o, 0);
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    frame(0, 0, 0, 9, 16'd1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_zynet_result_reader

// File: doc/zynet_result_reader.md
ZYNET_RESULT_READER -- requirements
Module: zynet_result_reader

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning the signed fixed-point score width.
REQ-002 SHALL have parameter OUTPUT_SIZE, default 10, meaning the number of class scores per frame.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_i, input, OUTPUT_SIZE*WORD_SIZE bits: network score vector; score k occupies bits [(k+1)*WORD_SIZE-1 : k*WORD_SIZE].
REQ-006 SHALL have port valid_i, input, 1 bit: score vector valid.
REQ-007 SHALL have port yumi_o, output, 1 bit: vector consumed this cycle.
REQ-008 SHALL have port data_o, output, WORD_SIZE bits: serialized score.
REQ-009 SHALL have port valid_o, output, 1 bit: data_o valid.
REQ-010 SHALL have port ready_i, input, 1 bit: downstream accepts data_o.
REQ-011 SHALL have port class_o, output, $clog2(OUTPUT_SIZE) bits: argmax index.
REQ-012 SHALL have port max_o, output, WORD_SIZE bits: the maximum score.
REQ-013 SHALL have port class_valid_o, output, 1 bit: class_o and max_o valid.
REQ-014 SHALL have port class_ready_i, input, 1 bit: class result accepted.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, STREAM, RESULT.
REQ-016 In IDLE, yumi_o SHALL equal valid_i combinationally; on valid_i=1 the vector is registered and the FSM moves to STREAM; index, best_idx and best_val are cleared.
REQ-017 yumi_o SHALL be 0 in STREAM and RESULT; valid_i is ignored there and data_i may change freely.
REQ-018 In STREAM, valid_o SHALL be 1 and data_o SHALL be registered score[index]; the first valid_o appears the cycle after capture.
REQ-019 A transfer SHALL occur when valid_o & ready_i; on each transfer index increments, and if index==0 or score[index] > best_val (signed compare) then best_val/best_idx are updated.
REQ-020 Ties SHALL resolve to the lowest index (strict greater-than).
REQ-021 On the transfer with index==OUTPUT_SIZE-1, the final compare SHALL be included, the FSM SHALL go to RESULT, and index SHALL wrap to 0.
REQ-022 While ready_i=0, data_o, valid_o and index SHALL hold stable.
REQ-023 In RESULT, class_valid_o SHALL be 1 with class_o/max_o stable; on class_ready_i=1 the FSM SHALL return to IDLE the next cycle.
REQ-024 Minimum frame period SHALL be OUTPUT_SIZE+2 cycles (1 capture, OUTPUT_SIZE stream, 1 result) with ready_i and class_ready_i held high.
REQ-025 Outside STREAM, valid_o SHALL be 0; outside RESULT, class_valid_o SHALL be 0.

Reset
REQ-026 Assertion of reset_n_i=0 SHALL immediately force IDLE and clear index, best_idx, best_val and the captured vector, in any state including mid-stream.
REQ-027 During and after reset, outputs SHALL be: yumi_o=valid_i-gated-by-IDLE, data_o=0, valid_o=0, class_o=0, max_o=0, class_valid_o=0.
REQ-028 A partial frame interrupted by reset SHALL be discarded; no class result is produced for it.

Structure
REQ-029 The state enum typedef and default WORD_SIZE/OUTPUT_SIZE constants SHALL reside in the shared package zynet_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the signed compare is inline.

Verification
REQ-031 Scores {1,5,-3,9,2,0,-8,4,7,3} (WORD_SIZE=16), ready_i=1, class_ready_i=1 -> data_o streams those 10 values in order; class_o=3, max_o=9; frame takes 12 cycles.
REQ-032 All scores -5 except score6=-2 -> class_o=6, max_o=-2 (signed compare; 0xFFFE beats 0xFFFB).
REQ-033 Scores {4,9,9,1,...,0} -> class_o=1 (tie to lowest index).
REQ-034 ready_i toggled 1,0,0,1,... during STREAM -> data_o/index hold while ready_i=0; exactly 10 transfers; result unchanged vs REQ-031.
REQ-035 valid_i held high with changing data_i during STREAM/RESULT -> yumi_o stays 0 and output is unaffected; next vector is accepted the cycle after class_ready_i handshake.
REQ-036 reset_n_i pulsed low after 4th transfer -> valid_o=0, class_valid_o=0 at once; new frame {0,0,0,0,0,0,0,0,0,1} then gives class_o=9, max_o=1.
